// File: rtl/uart_ctrl.sv
// LPC-side UART controller: host-facing TX/RX byte FIFOs, sticky error status,
// and a TX sequencer that hands bytes to the transmitter and waits for tx_busy.
//
// state   | meaning
// S_IDLE  | waiting for a queued byte while transmitter is not busy
// S_ISSUE | one-cycle tx_data_valid strobe to the transmitter
// S_ACK   | waiting (bounded) for tx_busy to rise
// S_DRAIN | transmitter busy; waiting for tx_busy to fall
module uart_ctrl #(
   parameter int DEPTH       = 8,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic       LPC_CLK,
   input  logic       LPC_RST,
   input  logic       host_wr,
   input  logic [7:0] host_wr_data,
   input  logic       host_rd,
   output logic [7:0] host_rd_data,
   input  logic       host_status_rd,
   output logic [7:0] status,
   output logic [7:0] tx_data,
   output logic       tx_data_valid,
   input  logic       tx_busy,
   input  logic [7:0] rx_data,
   input  logic       rx_data_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [TW-1:0] T_LOAD   = TW'(ACK_TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_DRAIN} state_t;

   state_t          state, state_nx;
   logic [TW-1:0]   timer, timer_nx;

   logic [7:0]      tx_mem [DEPTH];
   logic [AW-1:0]   tx_wptr, tx_rptr;
   logic [CW-1:0]   tx_cnt;
   logic            tx_empty, tx_full, tx_push, tx_pop;

   logic [7:0]      rx_mem [DEPTH];
   logic [AW-1:0]   rx_wptr, rx_rptr;
   logic [CW-1:0]   rx_cnt;
   logic            rx_empty, rx_full, rx_push, rx_pop;

   logic            rx_overrun, tx_dropped, tx_idle;

   assign tx_empty = (tx_cnt == '0);
   assign tx_full  = (tx_cnt == CNT_FULL);
   assign tx_pop   = (state == S_IDLE) && !tx_empty && !tx_busy;
   // a full FIFO still accepts a write on the edge the sequencer frees a slot
   assign tx_push  = host_wr && (!tx_full || tx_pop);

   assign rx_empty = (rx_cnt == '0);
   assign rx_full  = (rx_cnt == CNT_FULL);
   assign rx_pop   = host_rd && !rx_empty;
   assign rx_push  = rx_data_valid && (!rx_full || rx_pop);

   always_ff @(posedge LPC_CLK) begin
      if (tx_push) tx_mem[tx_wptr] <= host_wr_data;
      if (rx_push) rx_mem[rx_wptr] <= rx_data;
   end

   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         tx_cnt  <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + 1'b1;
            2'b01:   tx_cnt <= tx_cnt - 1'b1;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         rx_wptr <= '0;
         rx_rptr <= '0;
         rx_cnt  <= '0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + 1'b1;
            2'b01:   rx_cnt <= rx_cnt - 1'b1;
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   assign host_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rptr];

   // sticky errors: a set event on the clearing edge takes priority
   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         rx_overrun <= 1'b0;
         tx_dropped <= 1'b0;
      end else begin
         if (rx_data_valid && !rx_push) rx_overrun <= 1'b1;
         else if (host_status_rd)       rx_overrun <= 1'b0;
         if (host_wr && !tx_push)       tx_dropped <= 1'b1;
         else if (host_status_rd)       tx_dropped <= 1'b0;
      end
   end

   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         state   <= S_IDLE;
         timer   <= '0;
         tx_data <= 8'h00;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         if (tx_pop) tx_data <= tx_mem[tx_rptr];
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      case (state)
         S_IDLE: begin
            if (!tx_empty && !tx_busy) state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            state_nx = S_ACK;
            timer_nx = T_LOAD;
         end
         S_ACK: begin
            if (tx_busy) begin
               state_nx = S_DRAIN;
               timer_nx = '0;
            end else if (timer <= TW'(1)) begin
               // no acknowledge in time: treat the byte as sent
               state_nx = S_IDLE;
               timer_nx = '0;
            end else begin
               timer_nx = timer - 1'b1;
            end
         end
         S_DRAIN: begin
            if (!tx_busy) state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
            timer_nx = '0;
         end
      endcase
   end

   assign tx_data_valid = (state == S_ISSUE);
   assign tx_idle       = tx_empty && (state == S_IDLE) && !tx_busy;
   assign status        = {1'b0, tx_idle, tx_empty, 1'b0,
                           tx_dropped, tx_full, rx_overrun, !rx_empty};

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_ctrl;

   localparam int DEPTH  = 8;
   localparam int ACK_TO = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       host_wr = 1'b0;
   logic [7:0] host_wr_data = 8'h00;
   logic       host_rd = 1'b0;
   logic [7:0] host_rd_data;
   logic       host_status_rd = 1'b0;
   logic [7:0] status;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_busy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_valid = 1'b0;

   always #5 clk = ~clk;

   uart_ctrl #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
      .LPC_CLK        (clk),
      .LPC_RST        (rst_n),
      .host_wr        (host_wr),
      .host_wr_data   (host_wr_data),
      .host_rd        (host_rd),
      .host_rd_data   (host_rd_data),
      .host_status_rd (host_status_rd),
      .status         (status),
      .tx_data        (tx_data),
      .tx_data_valid  (tx_data_valid),
      .tx_busy        (tx_busy),
      .rx_data        (rx_data),
      .rx_data_valid  (rx_data_valid)
   );

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model. xfer_age: -1 no transfer, 0 strobe cycle,
   // 1..ACK_TO cycles waited for acknowledge; acked: transmitter took the byte.
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   int         xfer_age = -1;
   bit         acked = 1'b0;
   logic [7:0] m_txd = 8'h00;
   bit         m_over = 1'b0;
   bit         m_drop = 1'b0;
   bit         over_ev, drop_ev;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txq.delete();
         rxq.delete();
         xfer_age = -1;
         acked = 1'b0;
         m_txd = 8'h00;
         m_over = 1'b0;
         m_drop = 1'b0;
      end else begin
         over_ev = 1'b0;
         drop_ev = 1'b0;
         if (xfer_age < 0) begin
            if (txq.size() != 0 && !tx_busy) begin
               m_txd = txq.pop_front();
               xfer_age = 0;
            end
         end else if (xfer_age == 0) begin
            xfer_age = 1;
            acked = 1'b0;
         end else if (!acked) begin
            if (tx_busy) acked = 1'b1;
            else if (xfer_age >= ACK_TO) xfer_age = -1;
            else xfer_age++;
         end else if (!tx_busy) begin
            xfer_age = -1;
            acked = 1'b0;
         end
         if (host_wr) begin
            if (txq.size() < DEPTH) txq.push_back(host_wr_data);
            else drop_ev = 1'b1;
         end
         if (host_rd && rxq.size() != 0) void'(rxq.pop_front());
         if (rx_data_valid) begin
            if (rxq.size() < DEPTH) rxq.push_back(rx_data);
            else over_ev = 1'b1;
         end
         if (host_status_rd) begin
            m_over = 1'b0;
            m_drop = 1'b0;
         end
         if (over_ev) m_over = 1'b1;
         if (drop_ev) m_drop = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [7:0] es;
         logic [7:0] erd;
         es = {1'b0, (txq.size() == 0 && xfer_age < 0 && !tx_busy), (txq.size() == 0), 1'b0,
               m_drop, (txq.size() == DEPTH), m_over, (rxq.size() != 0)};
         erd = (rxq.size() != 0) ? rxq[0] : 8'h00;
         chk("status", status, es);
         chk("tx_data", tx_data, m_txd);
         chk("tx_data_valid", {7'd0, tx_data_valid}, {7'd0, (xfer_age == 0)});
         chk("host_rd_data", host_rd_data, erd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #1 rst_n = 1'b0;
      cmp_en = 1'b1;
      tick();
      chk("rst_status", status, 8'h60);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_valid", {7'd0, tx_data_valid}, 8'h00);
      chk("rst_rd_data", host_rd_data, 8'h00);
      rst_n = 1'b1;
      tick();

      // single byte with acknowledging transmitter
      host_wr = 1'b1; host_wr_data = 8'h41;
      tick();
      host_wr = 1'b0;
      chk("wr_no_issue_yet", {7'd0, tx_data_valid}, 8'h00);
      tick();
      chk("issue_valid", {7'd0, tx_data_valid}, 8'h01);
      chk("issue_data", tx_data, 8'h41);
      tick();
      tx_busy = 1'b1;
      chk("valid_one_pulse", {7'd0, tx_data_valid}, 8'h00);
      repeat (10) tick();
      tx_busy = 1'b0;
      chk("status_drain", status, 8'h20);
      tick();
      chk("status_idle_again", status, 8'h60);
      chk("tx_data_held", tx_data, 8'h41);

      // TX overflow with transmitter held busy
      tx_busy = 1'b1;
      for (int i = 0; i < 9; i++) begin
         host_wr = 1'b1; host_wr_data = 8'(i);
         tick();
         if (i == 7) chk("tx_full_after8", status, 8'h04);
      end
      host_wr = 1'b0;
      chk("tx_dropped_set", status, 8'h0C);
      host_status_rd = 1'b1;
      tick();
      host_status_rd = 1'b0;
      chk("tx_dropped_clear", status, 8'h04);
      tx_busy = 1'b0;
      n = 0;
      while (status !== 8'h60 && n < 200) begin tick(); n++; end
      chk("tx_drain_done", status, 8'h60);
      chk("tx_last_sent", tx_data, 8'h07);

      // RX full with simultaneous push/pop, then overrun
      for (int i = 0; i < 8; i++) begin
         rx_data_valid = 1'b1; rx_data = 8'(8'h10 + i);
         tick();
      end
      rx_data = 8'h18; host_rd = 1'b1;
      tick();
      rx_data_valid = 1'b0; host_rd = 1'b0;
      chk("rx_pushpop_head", host_rd_data, 8'h11);
      chk("rx_pushpop_status", status, 8'h61);
      rx_data_valid = 1'b1; rx_data = 8'h19;
      tick();
      rx_data_valid = 1'b0;
      chk("rx_overrun_status", status, 8'h63);
      chk("rx_overrun_head", host_rd_data, 8'h11);
      host_status_rd = 1'b1;
      tick();
      host_status_rd = 1'b0;
      chk("rx_overrun_clear", status, 8'h61);
      for (int i = 0; i < 8; i++) begin
         chk("rx_order", host_rd_data, 8'(8'h11 + i));
         host_rd = 1'b1;
         tick();
         host_rd = 1'b0;
      end
      chk("rx_empty_status", status, 8'h60);
      host_rd = 1'b1;
      tick();
      host_rd = 1'b0;
      chk("rx_empty_rd", host_rd_data, 8'h00);
      chk("rx_empty_rd_status", status, 8'h60);

      // acknowledge timeout, next byte still issues
      host_wr = 1'b1; host_wr_data = 8'h55;
      tick();
      host_wr_data = 8'h66;
      tick();
      host_wr = 1'b0;
      chk("to_issue1_valid", {7'd0, tx_data_valid}, 8'h01);
      chk("to_issue1_data", tx_data, 8'h55);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("to_wait_valid", {7'd0, tx_data_valid}, 8'h00);
      end
      tick();
      chk("to_issue2_valid", {7'd0, tx_data_valid}, 8'h01);
      chk("to_issue2_data", tx_data, 8'h66);
      n = 0;
      while (status !== 8'h60 && n < 50) begin tick(); n++; end
      chk("to_no_hang", status, 8'h60);

      // reset during drain with three bytes queued
      host_wr = 1'b1; host_wr_data = 8'hA1;
      tick();
      host_wr = 1'b0;
      tick();
      tx_busy = 1'b1;
      host_wr = 1'b1; host_wr_data = 8'hB1;
      tick();
      host_wr_data = 8'hB2;
      tick();
      host_wr_data = 8'hB3;
      tick();
      host_wr = 1'b0;
      chk("drain_queued_status", status, 8'h00);
      rst_n = 1'b0;
      tx_busy = 1'b0;
      #1;
      chk("async_rst_tx_data", tx_data, 8'h00);
      chk("async_rst_valid", {7'd0, tx_data_valid}, 8'h00);
      chk("async_rst_status", status, 8'h60);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("post_rst_no_issue", {7'd0, tx_data_valid}, 8'h00);
      end
      chk("post_rst_status", status, 8'h60);

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) tx_busy = ~tx_busy;
         host_wr        = ($urandom_range(0, 2) == 0);
         host_wr_data   = 8'($urandom);
         host_rd        = (((c / 500) % 2) == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
         host_status_rd = ($urandom_range(0, 15) == 0);
         rx_data_valid  = ($urandom_range(0, 2) == 0);
         rx_data        = 8'($urandom);
         rst_n          = ($urandom_range(0, 999) != 0);
         tick();
      end
      rst_n = 1'b1;
      host_wr = 1'b0; host_rd = 1'b0; host_status_rd = 1'b0; rx_data_valid = 1'b0;
      tick();
      cmp_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
